// File: rtl/pe_lsu_if.sv
// TCDM-style req/gnt/rvalid memory port between a PE load/store unit (master)
// and the tile memory interconnect (slave).
interface pe_lsu_if;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/pe_lsu.sv
// Per-PE load/store unit: LOAD/STORE opcodes -> one TCDM transaction each.
// Optional macro LSU_TIMEOUT_EN adds a REQ/WAIT_RV watchdog and a sticky lsu_err_o.
module pe_lsu #(
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Exec_En_Global,
    input  logic              LSU_En,
    input  logic [4:0]        Opcode,
    input  logic [31:0]       Addr_In,
    input  logic [31:0]       Offset_In,
    input  logic [DWIDTH-1:0] Store_Data_In,
    pe_lsu_if.master          bus,
    output logic [31:0]       load_data_o,
    output logic              data_req_valid_o,
    output logic              lsu_busy_o,
    output logic              lsu_err_o
);
    localparam logic [4:0] OP_LOAD  = 5'b00111;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RV} state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        vld_q, vld_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ldata_q, ldata_d;
    logic [31:0] sum;
    logic        accept;

    assign sum    = Addr_In + Offset_In;
    assign accept = LSU_En && Exec_En_Global && (Opcode == OP_LOAD || Opcode == OP_STORE);

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          expire;

    // Abort on the edge where the counter would reach TIMEOUT.
    assign expire = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        vld_d   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = {sum[31:2], 2'b00};
                    we_d    = (Opcode == OP_STORE);
                    wdata_d = 32'(Store_Data_In);
                    req_d   = 1'b1;
                    state_d = REQ;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            REQ: begin
                if (bus.data_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = WAIT_RV;
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (expire) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        ldata_d = '0;
                        vld_d   = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            WAIT_RV: begin
                if (bus.data_rvalid_i) begin
                    state_d = IDLE;
                    if (!we_q) begin
                        ldata_d = 32'(bus.data_rdata_i[DWIDTH-1:0]);
                        vld_d   = 1'b1;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if (expire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    if (!we_q) begin
                        ldata_d = '0;
                        vld_d   = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            vld_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            vld_q   <= vld_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.data_req_o   = req_q;
    assign bus.data_addr_o  = addr_q;
    assign bus.data_we_o    = we_q;
    assign bus.data_be_o    = 4'b1111;
    assign bus.data_wdata_o = wdata_q;
    assign load_data_o      = ldata_q;
    assign data_req_valid_o = vld_q;
    assign lsu_busy_o       = (state_q != IDLE);
`ifdef LSU_TIMEOUT_EN
    assign lsu_err_o        = err_q;
`else
    assign lsu_err_o        = 1'b0;
`endif
endmodule

// File: doc/pe_lsu.md
Name: pe_lsu

Overview:
Per-PE load/store unit for the CGRA tile. It sits directly upstream of the PE ALU and turns LOAD/STORE opcodes into TCDM-style req/gnt/rvalid memory transactions. For loads it returns the read word as load_data_o with a one-cycle data_req_valid_o pulse, which feeds the ALU's load_data_i / data_req_valid_i. lsu_busy_o lets the tile controller stall the PE while a transaction is in flight.

Parameters:
DWIDTH, 32, width of store data and load data returned to the ALU (must be ≤ 32; upper bits dropped/zero-extended)
TIMEOUT, 255, max cycles spent in REQ or WAIT_RV before abort (used only with LSU_TIMEOUT_EN)

Ports:
Clk  in  1  clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
Exec_En_Global  in  1  global execute enable; 0 blocks new issue, in-flight op completes
LSU_En  in  1  this PE's slot is a memory op this cycle
Opcode  in  5  5'b00111 = LOAD, 5'b01000 = STORE, others ignored
Addr_In  in  32  base byte address
Offset_In  in  32  byte offset added to base
Store_Data_In  in  DWIDTH  store data
data_req_o  out  1  memory request
data_gnt_i  in  1  request accepted
data_addr_o  out  32  word-aligned address
data_we_o  out  1  1 = store
data_be_o  out  4  byte enables, always 4'b1111
data_wdata_o  out  32  store data, zero-extended
data_rvalid_i  in  1  response valid
data_rdata_i  in  32  read data
load_data_o  out  32  captured load data, to ALU load_data_i
data_req_valid_o  out  1  one-cycle pulse, to ALU data_req_valid_i
lsu_busy_o  out  1  state != IDLE
lsu_err_o  out  1  sticky timeout flag

Behaviour:
- States: IDLE, REQ, WAIT_RV. All outputs registered except lsu_busy_o (decoded from state).
- Reset (sync, Reset=1 at edge): state IDLE; data_req_o, data_we_o, data_addr_o, data_wdata_o, load_data_o, data_req_valid_o, lsu_err_o all 0; data_be_o 4'b1111. Reset mid-transaction abandons it at once: no data_req_valid_o pulse; any late gnt/rvalid is ignored.
- IDLE: accept when LSU_En & Exec_En_Global & Opcode ∈ {LOAD, STORE}. On accept:
  - data_addr_o <= {sum[31:2], 2'b00}, where sum = Addr_In + Offset_In mod 2^32. Low two bits are discarded with no misalignment error.
  - data_we_o <= (Opcode == STORE); data_wdata_o <= Store_Data_In; data_req_o <= 1; go to REQ.
- REQ: data_req_o, addr, we and wdata are held stable until data_gnt_i = 1. On gnt: data_req_o <= 0; go to WAIT_RV.
- WAIT_RV: data_rvalid_i in the same cycle as gnt is not legal and is ignored; rvalid arrives ≥1 cycle after gnt. On data_rvalid_i:
  - LOAD: load_data_o <= data_rdata_i and data_req_valid_o <= 1 for exactly one cycle.
  - STORE: no pulse.
  - In both cases go to IDLE.
- Minimum load latency: accept edge at cycle 0; req visible cycle 1; gnt in cycle 1; rvalid in cycle 2; data_req_valid_o high in cycle 3.
- Back-to-back: a new op may be accepted in the cycle data_req_valid_o is high, since the state is already IDLE.
- Op fields present while not IDLE are ignored; the controller must hold them until lsu_busy_o falls.
- load_data_o holds its value until the next load completes.
- Exec_En_Global falling mid-op does not abort it.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A cycle counter of width $clog2(TIMEOUT+1) clears on entry to REQ and to WAIT_RV, and increments each cycle without the awaited gnt/rvalid.
  - When the counter reaches TIMEOUT, the unit drops data_req_o, returns to IDLE and sets lsu_err_o (sticky, cleared only by Reset).
  - For an aborted LOAD, load_data_o <= 0 and data_req_valid_o pulses once so the PE does not hang.
- Not defined: no counter; lsu_err_o is tied 0; the unit waits indefinitely.

Test Plan:
- LOAD, Addr_In=0x100, Offset_In=0x8, gnt immediate, rvalid 1 cycle later with 0xCAFEF00D -> data_addr_o=0x108, we=0; load_data_o=0xCAFEF00D with a single-cycle data_req_valid_o in cycle 3.
- STORE, Addr_In=0x203 (misaligned), Offset_In=0, data 0x55, gnt delayed 4 cycles -> req/addr=0x200/wdata=0x55 held stable 5 cycles; we=1; no data_req_valid_o; busy drops after rvalid.
- Exec_En_Global=0 with LSU_En=1 LOAD -> no req; then Exec_En_Global drops while in WAIT_RV -> the transaction still completes and pulses.
- Reset asserted in WAIT_RV, then rvalid arrives -> IDLE, no pulse, all outputs 0.
- Back-to-back: two LOADs, second presented in the pulse cycle of the first -> second req issued on the next cycle with no gap; data 0x1 then 0x2 returned in order.
- With LSU_TIMEOUT_EN and TIMEOUT=8, gnt never asserted -> data_req_o drops after 8 cycles, lsu_err_o=1 and stays 1, data_req_valid_o pulses with load_data_o=0.
